muxnx1_scan: RTL and testbench
==============================

// Module: muxnx1_scan
// PURPOSE
//   Parametrised N-channel, WIDTH-bit multiplexer with registered output; successor to the 2:1 mux.
//   Manual mode: channel taken from sel_i. Scan mode: internal counter steps through all
//   channels, holding each for DWELL cycles (replaces bench-driven toggling of select).
//   Sits between parallel data sources and a single downstream sampler/monitor.
// PARAMETERS
//   WIDTH  8  data bits per channel
//   N      4  number of input channels, >=2
//   DWELL  4  cycles each channel is held in scan mode, >=1
//   SELW   $clog2(N) (localparam)  channel index width
// PORTS
//   clk      in   1          clock, rising edge
//   rst_n    in   1          synchronous reset, active low
//   en       in   1          block enable; 0 freezes all state
//   mode     in   1          0 = manual select, 1 = auto scan
//   sel_i    in   SELW       manual channel index
//   d_i      in   N*WIDTH    packed inputs; channel k = d_i[k*WIDTH +: WIDTH]
//   y        out  WIDTH      registered selected data
//   y_valid  out  1          y holds a fresh sample this cycle
//   ch_o     out  SELW       channel index that produced current y
//   wrap     out  1          1-cycle pulse: scan advanced N-1 -> 0
//   sel_err  out  1          1-cycle pulse: manual sel_i >= N rejected
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): y=0, y_valid=0, ch_o=0, wrap=0, sel_err=0, dwell cnt=0, state=IDLE.
//   States: IDLE, MANUAL, SCAN. From any state each enabled edge: mode=0 -> MANUAL, mode=1 -> SCAN.
//     en=0 -> IDLE next; in IDLE outputs hold y/ch_o, y_valid=0, wrap=0, sel_err=0, counters frozen.
//   Latency: y at edge k+1 = d_i[ch] sampled at edge k (1 cycle); y_valid=1 every enabled cycle.
//   MANUAL: sel_i<N -> ch=sel_i. sel_i>=N -> ch holds previous value, sel_err=1 that cycle.
//     dwell cnt held at 0 in MANUAL.
//   SCAN: dwell cnt counts 0..DWELL-1; on edge with cnt==DWELL-1, cnt->0 and ch advances by 1.
//     ch==N-1 advancing -> ch=0 and wrap=1 for that one cycle; N non-power-of-2 must wrap at N-1.
//     DWELL=1: ch advances every enabled edge.
//   Mode change MANUAL->SCAN: scan starts from current ch, cnt=0 (full dwell on that channel).
//   Mode change SCAN->MANUAL: takes sel_i on the same edge; cnt cleared.
//   en 1->0->1 in SCAN: resumes same ch with remaining dwell count (no skip, no restart).
//   rst_n low mid-scan overrides en/mode: all state to reset values next edge.
//   y and ch_o always change on the same edge (ch_o identifies y, never the next channel).
// TESTING
//   1 Reset: rst_n=0 two cycles, en=1 -> y=0, y_valid=0, ch_o=0, wrap=0 after each edge.
//   2 Manual: N=4,W=8, d_i={8'hD3,8'hC2,8'hB1,8'hA0}, sel_i=2 -> next cycle y=8'hC2, ch_o=2, y_valid=1.
//   3 Scan: mode=1, DWELL=4 -> ch_o 0,0,0,0,1,1,1,1,2..3,0; wrap=1 only on the 3->0 cycle (every 16).
//   4 Freeze: scan at ch=1 cnt=2, en=0 3 cycles -> y/ch_o held, y_valid=0; en=1 -> 2 more cycles on ch1, then ch2.
//   5 Bad select: N=3, sel_i=3 after sel_i=1 -> ch_o stays 1, sel_err pulses 1 cycle.
//   6 Mid-op reset + N=5,DWELL=1: wrap every 5 cycles; rst_n=0 at ch=3 -> ch_o=0, y=0 next edge.
//   Each scenario: $monitor trace plus self-check against a reference model; dump VCD.

Source files
------------

// File: rtl/muxnx1_scan.sv
// N-channel registered multiplexer with manual select or automatic dwell-timed scan.
// The sampled channel index travels with the data so a downstream monitor can tag each sample.
module muxnx1_scan #(
   parameter  int WIDTH = 8,
   parameter  int N     = 4,
   parameter  int DWELL = 4,
   localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               mode,
   input  logic [SELW-1:0]    sel_i,
   input  logic [N*WIDTH-1:0] d_i,
   output logic [WIDTH-1:0]   y,
   output logic               y_valid,
   output logic [SELW-1:0]    ch_o,
   output logic               wrap,
   output logic               sel_err
);

   localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] MANUAL = 2'd1;
   localparam logic [1:0] SCAN   = 2'd2;

   logic [1:0]      state;
   logic [SELW-1:0] ch;
   logic [SELW-1:0] ch_sel;
   logic [SELW-1:0] ch_next;
   logic [CNTW-1:0] cnt;
   logic [CNTW-1:0] cnt_next;
   logic            sel_ok;
   logic            last;
   logic            wrap_next;

   // ch is the channel scan will use on the next enabled edge; ch_sel is the one used now.
   always_comb begin
      sel_ok    = ({1'b0, sel_i} < (SELW+1)'(N));
      last      = (cnt == CNTW'(DWELL - 1));
      ch_sel    = ch;
      ch_next   = ch;
      cnt_next  = cnt;
      wrap_next = 1'b0;
      if (!mode) begin
         if (sel_ok) ch_sel = sel_i;
         ch_next  = ch_sel;
         cnt_next = '0;
      end else if (last) begin
         cnt_next  = '0;
         wrap_next = (ch == SELW'(N - 1));
         ch_next   = wrap_next ? '0 : ch + 1'b1;
      end else begin
         cnt_next = cnt + 1'b1;
      end
   end

   // wrap marks the last dwell sample of channel N-1, the edge the scan rolls back to 0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         ch      <= '0;
         cnt     <= '0;
         y       <= '0;
         ch_o    <= '0;
         wrap    <= 1'b0;
         sel_err <= 1'b0;
      end else if (!en) begin
         state   <= IDLE;
         wrap    <= 1'b0;
         sel_err <= 1'b0;
      end else begin
         state   <= mode ? SCAN : MANUAL;
         ch      <= ch_next;
         cnt     <= cnt_next;
         y       <= d_i[ch_sel*WIDTH +: WIDTH];
         ch_o    <= ch_sel;
         wrap    <= mode & wrap_next;
         sel_err <= ~mode & ~sel_ok;
      end
   end

   assign y_valid = (state != IDLE);

endmodule

// File: tb/tb_muxnx1_scan.sv
// Bench for muxnx1_scan: three configurations (N=4/DWELL=4, N=3/DWELL=2, N=5/DWELL=1)
// checked against a channel/dwell-position reference model plus directed spot checks.
module tb_muxnx1_scan;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, en_a, mode_a;
   logic [1:0]  sel_a;
   logic [31:0] d_a;
   logic [7:0]  y_a;
   logic        yv_a, wr_a, er_a;
   logic [1:0]  ch_a;

   logic        rst_b, en_b, mode_b;
   logic [1:0]  sel_b;
   logic [23:0] d_b;
   logic [7:0]  y_b;
   logic        yv_b, wr_b, er_b;
   logic [1:0]  ch_b;

   logic        rst_c, en_c, mode_c;
   logic [2:0]  sel_c;
   logic [39:0] d_c;
   logic [7:0]  y_c;
   logic        yv_c, wr_c, er_c;
   logic [2:0]  ch_c;

   muxnx1_scan #(.WIDTH(8), .N(4), .DWELL(4)) u_a (
      .clk(clk), .rst_n(rst_a), .en(en_a), .mode(mode_a), .sel_i(sel_a), .d_i(d_a),
      .y(y_a), .y_valid(yv_a), .ch_o(ch_a), .wrap(wr_a), .sel_err(er_a));

   muxnx1_scan #(.WIDTH(8), .N(3), .DWELL(2)) u_b (
      .clk(clk), .rst_n(rst_b), .en(en_b), .mode(mode_b), .sel_i(sel_b), .d_i(d_b),
      .y(y_b), .y_valid(yv_b), .ch_o(ch_b), .wrap(wr_b), .sel_err(er_b));

   muxnx1_scan #(.WIDTH(8), .N(5), .DWELL(1)) u_c (
      .clk(clk), .rst_n(rst_c), .en(en_c), .mode(mode_c), .sel_i(sel_c), .d_i(d_c),
      .y(y_c), .y_valid(yv_c), .ch_o(ch_c), .wrap(wr_c), .sel_err(er_c));

   int vectors = 0;
   int miscompares = 0;

   // Reference: scan channel and how many cycles of its dwell have been spent.
   int       m_ch[3];
   int       m_used[3];
   logic [7:0] e_y[3];
   int       e_cho[3];
   bit       e_yv[3], e_wr[3], e_er[3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mstep(input int i, input int n, input int dw, input bit rst, input bit en,
                        input bit mode, input int sel, input logic [39:0] d);
      int use_ch;
      if (!rst) begin
         m_ch[i] = 0; m_used[i] = 0; e_y[i] = 8'h00; e_cho[i] = 0;
         e_yv[i] = 0; e_wr[i] = 0; e_er[i] = 0;
      end else if (!en) begin
         e_yv[i] = 0; e_wr[i] = 0; e_er[i] = 0;
      end else begin
         e_yv[i] = 1; e_wr[i] = 0; e_er[i] = 0;
         if (!mode) begin
            m_used[i] = 0;
            if (sel < n) m_ch[i] = sel;
            else e_er[i] = 1;
            use_ch = m_ch[i];
         end else begin
            use_ch = m_ch[i];
            m_used[i]++;
            if (m_used[i] == dw) begin
               m_used[i] = 0;
               if (m_ch[i] == n - 1) e_wr[i] = 1;
               m_ch[i] = (m_ch[i] + 1) % n;
            end
         end
         e_y[i]   = d[use_ch*8 +: 8];
         e_cho[i] = use_ch;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      mstep(0, 4, 4, rst_a, en_a, mode_a, int'(sel_a), 40'(d_a));
      mstep(1, 3, 2, rst_b, en_b, mode_b, int'(sel_b), 40'(d_b));
      mstep(2, 5, 1, rst_c, en_c, mode_c, int'(sel_c), d_c);
      #1;
      chk("a_y", 32'(y_a), 32'(e_y[0]));   chk("a_valid", 32'(yv_a), 32'(e_yv[0]));
      chk("a_ch", 32'(ch_a), e_cho[0]);    chk("a_wrap", 32'(wr_a), 32'(e_wr[0]));
      chk("a_err", 32'(er_a), 32'(e_er[0]));
      chk("b_y", 32'(y_b), 32'(e_y[1]));   chk("b_valid", 32'(yv_b), 32'(e_yv[1]));
      chk("b_ch", 32'(ch_b), e_cho[1]);    chk("b_wrap", 32'(wr_b), 32'(e_wr[1]));
      chk("b_err", 32'(er_b), 32'(e_er[1]));
      chk("c_y", 32'(y_c), 32'(e_y[2]));   chk("c_valid", 32'(yv_c), 32'(e_yv[2]));
      chk("c_ch", 32'(ch_c), e_cho[2]);    chk("c_wrap", 32'(wr_c), 32'(e_wr[2]));
      chk("c_err", 32'(er_c), 32'(e_er[2]));
   endtask

   initial begin
      rst_a = 0; en_a = 1; mode_a = 0; sel_a = 0; d_a = $urandom;
      rst_b = 0; en_b = 1; mode_b = 0; sel_b = 0; d_b = 24'($urandom);
      rst_c = 0; en_c = 1; mode_c = 0; sel_c = 0; d_c = {8'($urandom), 32'($urandom)};

      // reset held two cycles with en=1
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("rst_y", 32'(y_a), 0);   chk("rst_valid", 32'(yv_a), 0);
         chk("rst_ch", 32'(ch_a), 0); chk("rst_wrap", 32'(wr_a), 0);
      end
      rst_a = 1; rst_b = 1; rst_c = 1;
      en_b = 0; en_c = 0;

      // manual select
      d_a = {8'hD3, 8'hC2, 8'hB1, 8'hA0}; sel_a = 2;
      cyc();
      chk("man_y", 32'(y_a), 32'h0C2); chk("man_ch", 32'(ch_a), 2); chk("man_valid", 32'(yv_a), 1);
      for (int i = 0; i < 12; i++) begin
         sel_a = 2'($urandom); d_a = $urandom;
         cyc();
      end

      // scan from channel 0: four cycles per channel, wrap on the 16th
      sel_a = 0; cyc();
      mode_a = 1;
      for (int i = 0; i < 34; i++) begin
         d_a = $urandom;
         cyc();
         chk("scan_ch", 32'(ch_a), (i / 4) % 4);
         chk("scan_wrap", 32'(wr_a), 32'((i % 16) == 15));
      end

      // freeze mid-dwell on channel 1 with two cycles already spent
      mode_a = 0; sel_a = 1; cyc();
      mode_a = 1; cyc(); cyc();
      en_a = 0;
      for (int i = 0; i < 3; i++) begin
         d_a = $urandom;
         cyc();
         chk("frz_valid", 32'(yv_a), 0); chk("frz_ch", 32'(ch_a), 1);
      end
      en_a = 1;
      cyc(); chk("res_ch0", 32'(ch_a), 1);
      cyc(); chk("res_ch1", 32'(ch_a), 1);
      cyc(); chk("res_ch2", 32'(ch_a), 2);

      // out-of-range manual select on N=3
      en_b = 1; mode_b = 0; sel_b = 1;
      cyc();
      sel_b = 3; cyc();
      chk("bad_ch", 32'(ch_b), 1); chk("bad_err", 32'(er_b), 1);
      sel_b = 0; cyc();
      chk("bad_clr", 32'(er_b), 0); chk("bad_ch0", 32'(ch_b), 0);

      // N=5, DWELL=1: channel advances each edge, wrap every five
      en_c = 1; mode_c = 1;
      for (int i = 0; i < 12; i++) begin
         d_c = {8'($urandom), 32'($urandom)};
         cyc();
         chk("n5_ch", 32'(ch_c), i % 5);
         chk("n5_wrap", 32'(wr_c), 32'((i % 5) == 4));
      end
      begin
         int k;
         for (k = 0; k < 10 && ch_c != 3; k++) cyc();
         chk("n5_reach3", 32'(ch_c), 3);
      end
      rst_c = 0; cyc();
      chk("mid_rst_y", 32'(y_c), 0); chk("mid_rst_ch", 32'(ch_c), 0);
      chk("mid_rst_valid", 32'(yv_c), 0);
      rst_c = 1;

      // randomized mixed traffic on all three
      en_a = 1; en_b = 1; en_c = 1;
      for (int i = 0; i < 400; i++) begin
         rst_a = ($urandom_range(63) != 0);
         rst_b = ($urandom_range(63) != 0);
         rst_c = ($urandom_range(63) != 0);
         en_a = ($urandom_range(7) != 0);
         en_b = ($urandom_range(7) != 0);
         en_c = ($urandom_range(7) != 0);
         if ($urandom_range(7) == 0) mode_a = ~mode_a;
         if ($urandom_range(7) == 0) mode_b = ~mode_b;
         if ($urandom_range(7) == 0) mode_c = ~mode_c;
         sel_a = 2'($urandom); sel_b = 2'($urandom); sel_c = 3'($urandom);
         d_a = $urandom; d_b = 24'($urandom); d_c = {8'($urandom), 32'($urandom)};
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
